serial_magnitude_comparator: RTL and testbench

//  Multi-cycle, parametrised magnitude comparator: compares two WIDTH-bit operands MSB-first, DIGIT bits per clock.

---
 rtl/serial_magnitude_comparator_if.sv | 26 ++
 rtl/serial_magnitude_comparator.sv | 110 +++++++++++
 tb/tb_serial_magnitude_comparator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and operand/result bundle for the serial magnitude comparator.
// The master issues compare requests; the slave (the comparator) reports
// progress and the registered verdict.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Operands are walked MSB-first, DIGIT bits
// per clock, and the walk stops at the first unequal digit. Signed operands
// are mapped to offset binary on load, so one unsigned digit compare serves
// both modes. All outputs come straight from flops.
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                        clk,
    input logic                        rst,
    serial_magnitude_comparator_if.slave bus
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject geometries the digit walk cannot handle.
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT (1 <= DIGIT <= WIDTH)");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] cnt;
    logic             gt_flag;
    logic             eq_flag;
    logic             lt_flag;

    logic [DIGIT-1:0] digit_a;
    logic [DIGIT-1:0] digit_b;
    logic             digit_ne;
    logic             digit_gt;
    logic             last_digit;
    logic             accept;

    // Compare the current most-significant digit of both shift registers.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        digit_a    = sa[WIDTH-1 -: DIGIT];
        digit_b    = sb[WIDTH-1 -: DIGIT];
        digit_ne   = (digit_a != digit_b);
        digit_gt   = (digit_a > digit_b);
        last_digit = (cnt == CNT_W'(NDIG - 1));
        accept     = bus.start && ((state == S_IDLE) || (state == S_DONE));
    end

    // Sequencer: load operands, step one digit per cycle, latch the verdict.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so each flop samples pre-edge values.
        if (rst) begin
            state   <= S_IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            gt_flag <= 1'b0;
            eq_flag <= 1'b0;
            lt_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        // Flipping the sign bit turns two's complement into offset
                        // binary, whose unsigned order matches the signed order.
                        sa      <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                        sb      <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                        cnt     <= '0;
                        gt_flag <= 1'b0;
                        eq_flag <= 1'b0;
                        lt_flag <= 1'b0;
                        state   <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (digit_ne) begin
                        gt_flag <= digit_gt;
                        lt_flag <= ~digit_gt;
                        eq_flag <= 1'b0;
                        state   <= S_DONE;
                    end else if (last_digit) begin
                        gt_flag <= 1'b0;
                        lt_flag <= 1'b0;
                        eq_flag <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        sa  <= sa << DIGIT;
                        sb  <= sb << DIGIT;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);
    assign bus.gt   = gt_flag;
    assign bus.eq   = eq_flag;
    assign bus.lt   = lt_flag;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for the serial magnitude comparator: a 16-bit/4-bit-digit instance
// and a 3-bit/1-bit-digit instance, both checked against an arithmetic
// reference model of ordering and first-differing-digit latency.
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator_if #(.WIDTH(16)) bus16 ();
    serial_magnitude_comparator_if #(.WIDTH(3))  bus3 ();

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    serial_magnitude_comparator #(.WIDTH(3), .DIGIT(1)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ordering from integer arithmetic; latency is 2 + index of the first
    // differing digit (MSB digit = 0), or NDIG+1 when the operands are equal.
    function automatic void ref_model(input int w, input int d, input logic [31:0] av,
                                      input logic [31:0] bv, input logic sm,
                                      output logic eg, output logic ee, output logic el,
                                      output int lat);
        longint ia, ib;
        int     ndig, mask;
        ia = longint'(av);
        ib = longint'(bv);
        if (sm && av[w-1]) ia = ia - (longint'(1) << w);
        if (sm && bv[w-1]) ib = ib - (longint'(1) << w);
        eg   = (ia > ib);
        ee   = (ia == ib);
        el   = (ia < ib);
        ndig = w / d;
        mask = (1 << d) - 1;
        lat  = ndig + 1;
        for (int j = ndig - 1; j >= 0; j--) begin
            int sh;
            sh = w - d * (j + 1);
            if (((av >> sh) & mask) != ((bv >> sh) & mask)) lat = j + 2;
        end
    endfunction

    task automatic check_idle16(input string tag, input logic [2:0] flags);
        check({tag, ":busy"}, {31'd0, bus16.busy}, 32'd0);
        check({tag, ":done"}, {31'd0, bus16.done}, 32'd0);
        check({tag, ":flags"}, {29'd0, bus16.gt, bus16.eq, bus16.lt}, {29'd0, flags});
    endtask

    // Called at a negedge: present a request for one cycle, then scramble the
    // operands to show they are not looked at after acceptance.
    task automatic launch16(input logic [15:0] av, input logic [15:0] bv, input logic sm);
        bus16.start       = 1'b1;
        bus16.a           = av;
        bus16.b           = bv;
        bus16.signed_mode = sm;
        @(negedge clk);
        bus16.start       = 1'b0;
        bus16.a           = 16'($urandom);
        bus16.b           = 16'($urandom);
        bus16.signed_mode = 1'($urandom);
    endtask

    // Runs from the first negedge after acceptance until done (bounded).
    task automatic await16(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                           input bit poke, input string tag);
        logic eg, ee, el;
        int   lat, n;
        ref_model(16, 4, 32'(av), 32'(bv), sm, eg, ee, el, lat);
        n = 1;
        while (bus16.done !== 1'b1 && n <= 20) begin
            check({tag, ":busy"}, {31'd0, bus16.busy}, 32'd1);
            check({tag, ":cleared"}, {29'd0, bus16.gt, bus16.eq, bus16.lt}, 32'd0);
            if (poke && n == 1) begin
                bus16.start       = 1'b1;
                bus16.a           = ~av;
                bus16.b           = 16'($urandom);
                bus16.signed_mode = ~sm;
            end
            @(negedge clk);
            bus16.start = 1'b0;
            n++;
        end
        check({tag, ":latency"}, 32'(n), 32'(lat));
        check({tag, ":busy_at_done"}, {31'd0, bus16.busy}, 32'd0);
        check({tag, ":result"}, {29'd0, bus16.gt, bus16.eq, bus16.lt}, {29'd0, eg, ee, el});
    endtask

    task automatic compare16(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                             input bit poke, input string tag);
        @(negedge clk);
        launch16(av, bv, sm);
        await16(av, bv, sm, poke, tag);
    endtask

    task automatic compare3(input logic [2:0] av, input logic [2:0] bv, input logic sm,
                            input string tag);
        logic eg, ee, el;
        int   lat, n;
        ref_model(3, 1, 32'(av), 32'(bv), sm, eg, ee, el, lat);
        @(negedge clk);
        bus3.start       = 1'b1;
        bus3.a           = av;
        bus3.b           = bv;
        bus3.signed_mode = sm;
        @(negedge clk);
        bus3.start = 1'b0;
        bus3.a     = 3'($urandom);
        bus3.b     = 3'($urandom);
        n = 1;
        while (bus3.done !== 1'b1 && n <= 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":latency"}, 32'(n), 32'(lat));
        check({tag, ":result"}, {29'd0, bus3.gt, bus3.eq, bus3.lt}, {29'd0, eg, ee, el});
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;

        bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.a = '0; bus16.b = '0;
        bus3.start  = 1'b0; bus3.signed_mode  = 1'b0; bus3.a  = '0; bus3.b  = '0;

        // Reset held two cycles, then idle with start low.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle16("reset_idle", 3'b000);
            check("reset_idle3", {27'd0, bus3.busy, bus3.done, bus3.gt, bus3.eq, bus3.lt}, 32'd0);
        end

        // Directed compares.
        compare16(16'h1234, 16'h1234, 1'b0, 1'b0, "eq_1234");
        @(negedge clk);
        check_idle16("eq_hold", 3'b010);
        compare16(16'h8000, 16'h7FFF, 1'b0, 1'b0, "unsigned_8000");
        compare16(16'h8000, 16'h7FFF, 1'b1, 1'b0, "signed_8000");
        compare16(16'h1235, 16'h1234, 1'b0, 1'b0, "gt_last_digit");
        compare16(16'hFFFF, 16'h0000, 1'b1, 1'b0, "signed_m1_vs_0");
        compare16(16'hFFFF, 16'h0000, 1'b0, 1'b0, "unsigned_ffff_vs_0");

        // Start and operand changes during RUN must not disturb the result.
        compare16(16'h1239, 16'h1234, 1'b0, 1'b1, "start_in_run");

        // Back-to-back: new request presented in the DONE cycle.
        compare16(16'h0123, 16'h0124, 1'b0, 1'b0, "b2b_first");
        launch16(16'h4000, 16'h3FFF, 1'b1);
        await16(16'h4000, 16'h3FFF, 1'b1, 1'b0, "b2b_second");
        @(negedge clk);
        check_idle16("b2b_hold", 3'b100);

        // Reset clears held flags.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle16("reset_clears_flags", 3'b000);

        // Reset two cycles into a RUN: abort, no done pulse afterwards.
        @(negedge clk);
        launch16(16'h1234, 16'h1234, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle16("reset_mid_run", 3'b000);
        repeat (6) begin
            @(negedge clk);
            check_idle16("no_done_after_abort", 3'b000);
        end

        // Single-bit digits on a 3-bit instance.
        compare3(3'd5, 3'd3, 1'b0, "w3_gt");
        compare3(3'd6, 3'd6, 1'b0, "w3_eq");
        compare3(3'd5, 3'd3, 1'b1, "w3_signed_lt");
        compare3(3'd2, 3'd3, 1'b0, "w3_lt_lsb");

        // Random sweep; half the pairs differ in a single digit so every
        // early-termination depth is exercised.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i % 2 == 0) begin
                int k;
                logic [15:0] m;
                k  = int'($urandom_range(0, 4));
                m  = 16'hF << (4 * (k % 4));
                rb = (k == 4) ? ra : ((ra & ~m) | (rb & m));
            end
            compare16(ra, rb, rs, 1'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
